rr_ex_stage: RTL and testbench
==============================

RR_EX_STAGE -- requirements
Module: rr_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, register/data width.
REQ-002 Parameter NREG, default 32, register count; index width 5.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
REQ-005 instr_rr  in  26  instruction from ID/RR: rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
REQ-006 opcode_rr  in  6  opcode from ID/RR.
REQ-007 RegWrite_rr, MemtoReg_rr, MemWrite_rr, ALUSrc_rr, RegDst_rr, Jump_rr, MemRead_rr  in  1 each  control bits from ID/RR.
REQ-008 ALUControl_rr  in  2  ALU control from ID/RR.
REQ-009 wb_we  in  1; wb_addr  in  5; wb_data  in  DATA_W  writeback write port.
REQ-010 stall_in  in  1  downstream hold request.
REQ-011 flush  in  1  taken branch/jump kill of the RR-stage instruction.
REQ-012 rd1_ex, rd2_ex  out  DATA_W  registered rs/rt operands.
REQ-013 imm_ex  out  DATA_W  registered sign-extended imm.
REQ-014 dest_ex  out  5  registered destination: rd if RegDst_rr else rt.
REQ-015 jtarget_ex  out  26  registered instr_rr.
REQ-016 opcode_ex  out  6; RegWrite_ex, MemtoReg_ex, MemWrite_ex, ALUSrc_ex, Jump_ex, MemRead_ex  out  1; ALUControl_ex  out  2  registered copies.
REQ-017 stall_out  out  1  combinational hold request to ID/RR and upstream.

Function
REQ-018 Register file: NREG x DATA_W flops; register 0 reads 0 always, writes to 0 ignored.
REQ-019 Write: on rising edge with wb_we=1 and wb_addr!=0, reg[wb_addr]<=wb_data; independent of stall_in/flush/hazard.
REQ-020 Read bypass: same-cycle write to rs (or rt), addr!=0, forwards wb_data to that operand.
REQ-021 Load-use hazard: hz=MemRead_ex & (dest_ex!=0) & (dest_ex==rs | (dest_ex==rt & (!ALUSrc_rr | MemWrite_rr))).
REQ-022 stall_out = hz | stall_in; combinational, zero-latency.
REQ-023 Edge-update priority: flush > stall_in > hz > normal.
REQ-024 flush=1: load bubble (all control outputs, opcode_ex, dest_ex = 0; data outputs don't-care, implemented as 0).
REQ-025 stall_in=1, flush=0: all pipeline outputs hold.
REQ-026 hz=1, stall_in=0, flush=0: load bubble as REQ-024; ID/RR holds, instruction re-evaluated next cycle.
REQ-027 Normal: all outputs capture operands, imm sign-extension, dest mux and pass-through inputs; latency 1 cycle.
REQ-028 Sign extension: imm_ex = {{(DATA_W-16){imm[15]}}, imm}.
REQ-029 Bubble clears MemRead_ex, so hz self-clears next cycle; single load-use costs exactly 1 bubble.

Reset
REQ-030 reset==0: all outputs of REQ-012..REQ-016 = 0 and all registers = 0 asynchronously, held while low.
REQ-031 stall_out during reset = 0 (all inputs to hz are 0, stall_in gated by reset).
REQ-032 First capture on first rising edge after reset deasserts; reset mid-stall discards held instruction.

Verification
REQ-033 Write reg5=0x1234 then rs=5, rt=0 add-type -> next edge rd1_ex=0x00001234, rd2_ex=0.
REQ-034 wb_we=1, wb_addr=7, wb_data=0xCAFE same cycle as rs=7 -> rd1_ex=0x0000CAFE (bypass); wb_addr=0 data 0xFFFF -> reg0 still 0.
REQ-035 Load lw to r3 in EX (MemRead_ex=1, dest_ex=3), RR has rs=3 -> stall_out=1 same cycle, next edge bubble (all controls 0), following edge instruction captured, stall_out=0.
REQ-036 Same as REQ-035 but rt=3, ALUSrc_rr=1, MemWrite_rr=0 -> stall_out=0, no bubble.
REQ-037 stall_in=1 for 3 cycles -> outputs constant, stall_out=1; flush=1 with stall_in=1 -> bubble wins.
REQ-038 imm=0x8000, RegDst=0, rt=9 -> imm_ex=0xFFFF8000, dest_ex=9; assert reset=0 mid-sequence -> all outputs 0 without clock edge.

Source files
------------

// File: rtl/rr_ex_stage.sv
// RR/EX pipeline stage: register file with write-through bypass, load-use hazard
// detection, and the registered EX-side operand/control bundle.
module rr_ex_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [25:0]       instr_rr,
    input  logic [5:0]        opcode_rr,
    input  logic              RegWrite_rr,
    input  logic              MemtoReg_rr,
    input  logic              MemWrite_rr,
    input  logic              ALUSrc_rr,
    input  logic              RegDst_rr,
    input  logic              Jump_rr,
    input  logic              MemRead_rr,
    input  logic [1:0]        ALUControl_rr,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              stall_in,
    input  logic              flush,
    output logic [DATA_W-1:0] rd1_ex,
    output logic [DATA_W-1:0] rd2_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [4:0]        dest_ex,
    output logic [25:0]       jtarget_ex,
    output logic [5:0]        opcode_ex,
    output logic              RegWrite_ex,
    output logic              MemtoReg_ex,
    output logic              MemWrite_ex,
    output logic              ALUSrc_ex,
    output logic              Jump_ex,
    output logic              MemRead_ex,
    output logic [1:0]        ALUControl_ex,
    output logic              stall_out
);

    typedef struct packed {
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        dest;
        logic [25:0]       jtarget;
        logic [5:0]        opcode;
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic              alu_src;
        logic              jump;
        logic              mem_read;
        logic [1:0]        alu_ctl;
    } ex_t;

    function automatic logic [DATA_W-1:0] sign_ext(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    ex_t               ex_q;
    ex_t               ex_d;
    ex_t               cap_s;

    logic [4:0]        rs_s;
    logic [4:0]        rt_s;
    logic [4:0]        rd_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] rd1_rf_s;
    logic [DATA_W-1:0] rd2_rf_s;
    logic              hz_s;

    assign rs_s    = instr_rr[25:21];
    assign rt_s    = instr_rr[20:16];
    assign rd_s    = instr_rr[15:11];
    assign wr_en_s = wb_we & (wb_addr != 5'd0);

    // Register file next state: register 0 is never written.
    always_comb begin
        regs_d    = regs_q;
        regs_d[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = (wr_en_s && (wb_addr == 5'(i))) ? wb_data : regs_q[i];
        end
    end

    // Register file read ports; index 0 and out-of-range indices read zero.
    always_comb begin
        rd1_rf_s = '0;
        rd2_rf_s = '0;
        for (int i = 1; i < NREG; i++) begin
            rd1_rf_s = (rs_s == 5'(i)) ? regs_q[i] : rd1_rf_s;
            rd2_rf_s = (rt_s == 5'(i)) ? regs_q[i] : rd2_rf_s;
        end
    end

    // Load-use hazard: rt only matters when it is actually read as a register.
    assign hz_s = ex_q.mem_read & (ex_q.dest != 5'd0) &
                  ((ex_q.dest == rs_s) |
                   ((ex_q.dest == rt_s) & (~ALUSrc_rr | MemWrite_rr)));

    // Gated by reset so the hold request is quiet while the stage is cleared.
    assign stall_out = reset & (hz_s | stall_in);

    // Capture bundle for a normally advancing instruction, with writeback bypass.
    always_comb begin
        cap_s            = '0;
        cap_s.rd1        = (wr_en_s && (wb_addr == rs_s)) ? wb_data : rd1_rf_s;
        cap_s.rd2        = (wr_en_s && (wb_addr == rt_s)) ? wb_data : rd2_rf_s;
        cap_s.imm        = sign_ext(instr_rr[15:0]);
        cap_s.dest       = RegDst_rr ? rd_s : rt_s;
        cap_s.jtarget    = instr_rr;
        cap_s.opcode     = opcode_rr;
        cap_s.reg_write  = RegWrite_rr;
        cap_s.mem_to_reg = MemtoReg_rr;
        cap_s.mem_write  = MemWrite_rr;
        cap_s.alu_src    = ALUSrc_rr;
        cap_s.jump       = Jump_rr;
        cap_s.mem_read   = MemRead_rr;
        cap_s.alu_ctl    = ALUControl_rr;
    end

    // Edge-update priority: flush, then downstream hold, then load-use bubble.
    always_comb begin
        ex_d = '0;
        if (flush) begin
            ex_d = '0;
        end else if (stall_in) begin
            ex_d = ex_q;
        end else if (hz_s) begin
            ex_d = '0;
        end else begin
            ex_d = cap_s;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_q   <= '0;
            regs_q <= '{default: '0};
        end else begin
            ex_q   <= ex_d;
            regs_q <= regs_d;
        end
    end

    assign rd1_ex        = ex_q.rd1;
    assign rd2_ex        = ex_q.rd2;
    assign imm_ex        = ex_q.imm;
    assign dest_ex       = ex_q.dest;
    assign jtarget_ex    = ex_q.jtarget;
    assign opcode_ex     = ex_q.opcode;
    assign RegWrite_ex   = ex_q.reg_write;
    assign MemtoReg_ex   = ex_q.mem_to_reg;
    assign MemWrite_ex   = ex_q.mem_write;
    assign ALUSrc_ex     = ex_q.alu_src;
    assign Jump_ex       = ex_q.jump;
    assign MemRead_ex    = ex_q.mem_read;
    assign ALUControl_ex = ex_q.alu_ctl;

endmodule

// File: tb/tb_rr_ex_stage.sv
// Table-driven bench for rr_ex_stage with an expected-output queue, plus
// hand-written stall/flush/reset sequences.
module tb_rr_ex_stage;

    typedef struct packed {
        logic [25:0] instr;
        logic [5:0]  opcode;
        logic        reg_write, mem_to_reg, mem_write, alu_src, reg_dst, jump, mem_read;
        logic [1:0]  alu_ctl;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        stall_in;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic [25:0] jt;
        logic [5:0]  opcode;
        logic        reg_write, mem_to_reg, mem_write, alu_src, jump, mem_read;
        logic [1:0]  alu_ctl;
    } ex_t;

    typedef struct {
        in_t  vin;
        logic stall;
        ex_t  exp;
    } vec_t;

    localparam logic [6:0] C_RW  = 7'b1000000;
    localparam logic [6:0] C_M2R = 7'b0100000;
    localparam logic [6:0] C_MW  = 7'b0010000;
    localparam logic [6:0] C_AS  = 7'b0001000;
    localparam logic [6:0] C_RD  = 7'b0000100;
    localparam logic [6:0] C_J   = 7'b0000010;
    localparam logic [6:0] C_MR  = 7'b0000001;
    localparam logic [6:0] C_LW  = C_RW | C_M2R | C_AS | C_MR;
    localparam ex_t        BUBBLE = '0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [25:0] instr_rr;
    logic [5:0]  opcode_rr;
    logic        RegWrite_rr, MemtoReg_rr, MemWrite_rr, ALUSrc_rr, RegDst_rr, Jump_rr, MemRead_rr;
    logic [1:0]  ALUControl_rr;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_in, flush;
    logic [31:0] rd1_ex, rd2_ex, imm_ex;
    logic [4:0]  dest_ex;
    logic [25:0] jtarget_ex;
    logic [5:0]  opcode_ex;
    logic        RegWrite_ex, MemtoReg_ex, MemWrite_ex, ALUSrc_ex, Jump_ex, MemRead_ex;
    logic [1:0]  ALUControl_ex;
    logic        stall_out;

    int   total = 0;
    int   bad   = 0;
    ex_t  exp_q [$];
    vec_t tbl [$];
    ex_t  got_ex;

    rr_ex_stage #(.DATA_W(32), .NREG(32)) dut (
        .clock(clock), .reset(reset),
        .instr_rr(instr_rr), .opcode_rr(opcode_rr),
        .RegWrite_rr(RegWrite_rr), .MemtoReg_rr(MemtoReg_rr), .MemWrite_rr(MemWrite_rr),
        .ALUSrc_rr(ALUSrc_rr), .RegDst_rr(RegDst_rr), .Jump_rr(Jump_rr), .MemRead_rr(MemRead_rr),
        .ALUControl_rr(ALUControl_rr),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_in(stall_in), .flush(flush),
        .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .imm_ex(imm_ex), .dest_ex(dest_ex),
        .jtarget_ex(jtarget_ex), .opcode_ex(opcode_ex),
        .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex), .MemWrite_ex(MemWrite_ex),
        .ALUSrc_ex(ALUSrc_ex), .Jump_ex(Jump_ex), .MemRead_ex(MemRead_ex),
        .ALUControl_ex(ALUControl_ex),
        .stall_out(stall_out)
    );

    always #5 clock = ~clock;

    assign got_ex = {rd1_ex, rd2_ex, imm_ex, dest_ex, jtarget_ex, opcode_ex,
                     RegWrite_ex, MemtoReg_ex, MemWrite_ex, ALUSrc_ex, Jump_ex, MemRead_ex,
                     ALUControl_ex};

    function automatic in_t mk_in(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [15:0] imm, input logic [5:0] opc,
                                  input logic [6:0] ctl, input logic [1:0] alu,
                                  input logic we, input logic [4:0] wa, input logic [31:0] wd);
        in_t v;
        v = '0;
        v.instr = {rs, rt, imm};
        v.opcode = opc;
        {v.reg_write, v.mem_to_reg, v.mem_write, v.alu_src, v.reg_dst, v.jump, v.mem_read} = ctl;
        v.alu_ctl = alu;
        v.wb_we = we;
        v.wb_addr = wa;
        v.wb_data = wd;
        return v;
    endfunction

    // Expected capture: data fields given by hand, pass-through fields from stimulus.
    function automatic ex_t cap(input in_t v, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [4:0] dest);
        ex_t e;
        e.rd1 = rd1;
        e.rd2 = rd2;
        e.imm = imm;
        e.dest = dest;
        e.jt = v.instr;
        e.opcode = v.opcode;
        e.reg_write = v.reg_write;
        e.mem_to_reg = v.mem_to_reg;
        e.mem_write = v.mem_write;
        e.alu_src = v.alu_src;
        e.jump = v.jump;
        e.mem_read = v.mem_read;
        e.alu_ctl = v.alu_ctl;
        return e;
    endfunction

    task automatic add(input in_t v, input logic s, input ex_t e);
        vec_t r;
        r.vin = v;
        r.stall = s;
        r.exp = e;
        tbl.push_back(r);
    endtask

    task automatic apply(input in_t v);
        instr_rr = v.instr;
        opcode_rr = v.opcode;
        RegWrite_rr = v.reg_write;
        MemtoReg_rr = v.mem_to_reg;
        MemWrite_rr = v.mem_write;
        ALUSrc_rr = v.alu_src;
        RegDst_rr = v.reg_dst;
        Jump_rr = v.jump;
        MemRead_rr = v.mem_read;
        ALUControl_rr = v.alu_ctl;
        wb_we = v.wb_we;
        wb_addr = v.wb_addr;
        wb_data = v.wb_data;
        stall_in = v.stall_in;
        flush = v.flush;
    endtask

    task automatic chk_ex(input ex_t exp, input string nm);
        total++;
        if (got_ex !== exp) begin
            bad++;
            $display("FAIL %s ex: got=%h want=%h", nm, got_ex, exp);
        end
    endtask

    task automatic chk_stall(input logic exp, input string nm);
        total++;
        if (stall_out !== exp) begin
            bad++;
            $display("FAIL %s stall_out: got=%b want=%b", nm, stall_out, exp);
        end
    endtask

    // One cycle: drive at negedge, check stall_out, queue expectation, compare after edge.
    task automatic step(input in_t v, input logic exp_stall, input ex_t exp_ex, input string nm);
        ex_t e;
        @(negedge clock);
        apply(v);
        #1;
        chk_stall(exp_stall, nm);
        exp_q.push_back(exp_ex);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s queue: got=empty want=entry", nm);
        end else begin
            e = exp_q.pop_front();
            chk_ex(e, nm);
        end
    endtask

    initial begin
        in_t v;
        ex_t e17;
        ex_t eh5;

        v = mk_in(5'd0, 5'd0, 16'h0000, 6'h00, 7'd0, 2'd0, 1'b1, 5'd5, 32'h1234);
        add(v, 1'b0, cap(v, 32'h0, 32'h0, 32'h0, 5'd0));
        v = mk_in(5'd5, 5'd0, 16'h5000, 6'h00, C_RW | C_RD, 2'b10, 1'b0, 5'd0, 32'h0);
        add(v, 1'b0, cap(v, 32'h1234, 32'h0, 32'h5000, 5'd10));
        v = mk_in(5'd7, 5'd5, 16'h0001, 6'h08, C_RW | C_AS, 2'b00, 1'b1, 5'd7, 32'hCAFE);
        add(v, 1'b0, cap(v, 32'hCAFE, 32'h1234, 32'h1, 5'd5));
        v = mk_in(5'd0, 5'd7, 16'h8000, 6'h0D, C_RW | C_AS, 2'b01, 1'b1, 5'd0, 32'hFFFF);
        add(v, 1'b0, cap(v, 32'h0, 32'hCAFE, 32'hFFFF8000, 5'd7));
        v = mk_in(5'd0, 5'd0, 16'h7FFF, 6'h0D, C_RW | C_AS, 2'b01, 1'b0, 5'd0, 32'h0);
        add(v, 1'b0, cap(v, 32'h0, 32'h0, 32'h7FFF, 5'd0));
        v = mk_in(5'd5, 5'd3, 16'h0004, 6'h23, C_LW, 2'b00, 1'b1, 5'd3, 32'h0BAD);
        add(v, 1'b0, cap(v, 32'h1234, 32'h0BAD, 32'h4, 5'd3));
        v = mk_in(5'd3, 5'd5, 16'h4000, 6'h00, C_RW | C_RD, 2'b10, 1'b0, 5'd0, 32'h0);
        add(v, 1'b1, BUBBLE);
        add(v, 1'b0, cap(v, 32'h0BAD, 32'h1234, 32'h4000, 5'd8));
        v = mk_in(5'd0, 5'd3, 16'h0008, 6'h23, C_LW, 2'b00, 1'b0, 5'd0, 32'h0);
        add(v, 1'b0, cap(v, 32'h0, 32'h0BAD, 32'h8, 5'd3));
        v = mk_in(5'd1, 5'd3, 16'h0010, 6'h08, C_RW | C_AS, 2'b00, 1'b0, 5'd0, 32'h0);
        add(v, 1'b0, cap(v, 32'h0, 32'h0BAD, 32'h10, 5'd3));
        v = mk_in(5'd0, 5'd4, 16'h000C, 6'h23, C_LW, 2'b00, 1'b0, 5'd0, 32'h0);
        add(v, 1'b0, cap(v, 32'h0, 32'h0, 32'hC, 5'd4));
        v = mk_in(5'd5, 5'd4, 16'h0000, 6'h2B, C_MW | C_AS, 2'b00, 1'b0, 5'd0, 32'h0);
        add(v, 1'b1, BUBBLE);
        add(v, 1'b0, cap(v, 32'h1234, 32'h0, 32'h0, 5'd4));
        v = mk_in(5'd0, 5'd0, 16'h0000, 6'h23, C_LW, 2'b00, 1'b0, 5'd0, 32'h0);
        add(v, 1'b0, cap(v, 32'h0, 32'h0, 32'h0, 5'd0));
        v = mk_in(5'd0, 5'd0, 16'h0000, 6'h00, C_RW | C_RD, 2'b10, 1'b0, 5'd0, 32'h0);
        add(v, 1'b0, cap(v, 32'h0, 32'h0, 32'h0, 5'd0));
        v = mk_in(5'd29, 5'd11, 16'hCDEF, 6'h02, C_J, 2'b00, 1'b0, 5'd0, 32'h0);
        add(v, 1'b0, cap(v, 32'h0, 32'h0, 32'hFFFFCDEF, 5'd11));
        v = mk_in(5'd5, 5'd7, 16'h1234, 6'h08, C_RW | C_AS, 2'b00, 1'b0, 5'd0, 32'h0);
        v.flush = 1'b1;
        add(v, 1'b0, BUBBLE);
        v = mk_in(5'd5, 5'd9, 16'h8000, 6'h08, C_RW | C_AS, 2'b00, 1'b0, 5'd0, 32'h0);
        e17 = cap(v, 32'h1234, 32'h0, 32'hFFFF8000, 5'd9);
        add(v, 1'b0, e17);

        // Reset asserted before any clock edge: outputs and stall_out must be zero.
        v = mk_in(5'd0, 5'd0, 16'h0, 6'h0, 7'd0, 2'd0, 1'b0, 5'd0, 32'h0);
        v.stall_in = 1'b1;
        apply(v);
        #1 reset = 1'b0;
        #1;
        chk_ex(BUBBLE, "reset_async");
        chk_stall(1'b0, "reset_async");
        @(posedge clock);
        #1;
        chk_ex(BUBBLE, "reset_held");
        chk_stall(1'b0, "reset_held");
        #2 reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vin, tbl[i].stall, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Downstream hold for three cycles; writeback still lands during the hold.
        v = mk_in(5'd7, 5'd7, 16'h5555, 6'h23, C_LW, 2'b11, 1'b1, 5'd9, 32'h99);
        v.stall_in = 1'b1;
        step(v, 1'b1, e17, "hold1");
        v.wb_we = 1'b0;
        step(v, 1'b1, e17, "hold2");
        step(v, 1'b1, e17, "hold3");
        v.flush = 1'b1;
        step(v, 1'b1, BUBBLE, "flush_over_stall");

        v = mk_in(5'd5, 5'd9, 16'h0002, 6'h08, C_RW | C_AS, 2'b00, 1'b0, 5'd0, 32'h0);
        eh5 = cap(v, 32'h1234, 32'h99, 32'h2, 5'd9);
        step(v, 1'b0, eh5, "after_hold");
        v = mk_in(5'd7, 5'd5, 16'h0F0F, 6'h00, C_RW | C_RD, 2'b10, 1'b0, 5'd0, 32'h0);
        v.stall_in = 1'b1;
        step(v, 1'b1, eh5, "hold_before_reset");

        // Reset mid-stall between edges clears everything without a clock edge.
        #2 reset = 1'b0;
        #1;
        chk_ex(BUBBLE, "mid_reset_async");
        chk_stall(1'b0, "mid_reset_stall");
        @(posedge clock);
        #1;
        chk_ex(BUBBLE, "mid_reset_held");
        @(negedge clock);
        reset = 1'b1;

        v = mk_in(5'd5, 5'd7, 16'h0003, 6'h08, C_RW | C_AS, 2'b00, 1'b0, 5'd0, 32'h0);
        step(v, 1'b0, cap(v, 32'h0, 32'h0, 32'h3, 5'd7), "post_reset_regs_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
